// File: rtl/meter_payment_arbiter.sv
// Command arbiter for the parking meter: serialises payment and admin preset
// requests into single-cycle meter pulses and keeps revenue/transaction tallies.
module meter_payment_arbiter #(
    parameter int NREQ    = 4,
    parameter int GAP     = 2,
    parameter int TALLY_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       amt,
    input  logic                    adm16_req,
    input  logic                    adm150_req,
    output logic                    add1,
    output logic                    add2,
    output logic                    add3,
    output logic                    add4,
    output logic                    rst1_o,
    output logic                    rst2_o,
    output logic [NREQ-1:0]         ack,
    output logic                    adm_ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [TALLY_W-1:0]      tally,
    output logic [7:0]              txn_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           add_q;
    logic                 rst1_q;
    logic                 rst2_q;
    logic [NREQ-1:0]      ack_q;
    logic                 adm_ack_q;
    logic [IDW-1:0]       grant_id_q;
    logic                 busy_q;
    logic [TALLY_W-1:0]   tally_q;
    logic [7:0]           txn_q;

    logic                 win_found_d;
    logic [IDW-1:0]       win_idx_d;
    logic [1:0]           win_amt_d;
    logic [8:0]           win_secs_d;
    logic [TALLY_W:0]     sum_d;
    logic [TALLY_W-1:0]   tally_d;
    int unsigned          cand;

    // Round-robin search starting at ptr_q, wrapping without a modulo operator.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found_d && req[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = IDW'(cand);
            end
        end
    end

    always_comb begin
        win_amt_d = amt[2*int'(win_idx_d) +: 2];
        case (win_amt_d)
            2'b00:   win_secs_d = 9'd60;
            2'b01:   win_secs_d = 9'd120;
            2'b10:   win_secs_d = 9'd180;
            default: win_secs_d = 9'd300;
        endcase
        sum_d   = {1'b0, tally_q} + (TALLY_W + 1)'(win_secs_d);
        tally_d = sum_d[TALLY_W] ? '1 : sum_d[TALLY_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            add_q      <= '0;
            rst1_q     <= 1'b0;
            rst2_q     <= 1'b0;
            ack_q      <= '0;
            adm_ack_q  <= 1'b0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            tally_q    <= '0;
            txn_q      <= '0;
        end else begin
            add_q     <= '0;
            rst1_q    <= 1'b0;
            rst2_q    <= 1'b0;
            ack_q     <= '0;
            adm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (adm150_req) begin
                        rst2_q    <= 1'b1;
                        adm_ack_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end else if (adm16_req) begin
                        rst1_q    <= 1'b1;
                        adm_ack_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end else if (win_found_d) begin
                        add_q      <= 4'b0001 << win_amt_d;
                        ack_q      <= NREQ'(1) << win_idx_d;
                        grant_id_q <= win_idx_d;
                        ptr_q      <= (win_idx_d == IDW'(NREQ - 1)) ? '0 : win_idx_d + 1'b1;
                        tally_q    <= tally_d;
                        txn_q      <= txn_q + 8'd1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CW'(GAP);
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign add1      = add_q[0];
    assign add2      = add_q[1];
    assign add3      = add_q[2];
    assign add4      = add_q[3];
    assign rst1_o    = rst1_q;
    assign rst2_o    = rst2_q;
    assign ack       = ack_q;
    assign adm_ack   = adm_ack_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign tally     = tally_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_meter_payment_arbiter.sv
// Directed bench for meter_payment_arbiter: reset state, round-robin order,
// admin priority, tally saturation, reset abort and amount sampling.
module tb_meter_payment_arbiter;

    localparam int NREQ    = 4;
    localparam int GAP     = 2;
    localparam int TALLY_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    amt;
    logic                 adm16_req;
    logic                 adm150_req;
    logic                 add1, add2, add3, add4, rst1_o, rst2_o;
    logic [NREQ-1:0]      ack;
    logic                 adm_ack;
    logic [1:0]           grant_id;
    logic                 busy;
    logic [TALLY_W-1:0]   tally;
    logic [7:0]           txn_count;
    logic [5:0]           pulses;

    int n_checks = 0;
    int n_fail   = 0;

    meter_payment_arbiter #(.NREQ(NREQ), .GAP(GAP), .TALLY_W(TALLY_W)) dut (
        .clk(clk), .rst(rst), .req(req), .amt(amt),
        .adm16_req(adm16_req), .adm150_req(adm150_req),
        .add1(add1), .add2(add2), .add3(add3), .add4(add4),
        .rst1_o(rst1_o), .rst2_o(rst2_o), .ack(ack), .adm_ack(adm_ack),
        .grant_id(grant_id), .busy(busy), .tally(tally), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    assign pulses = {rst2_o, rst1_o, add4, add3, add2, add1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; amt = '0; adm16_req = 1'b0; adm150_req = 1'b0;
        step(); step();
        check("rst_pulses", pulses, 6'b0);
        check("rst_ack", ack, 4'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_tally", tally, 16'd0);
        check("rst_txn", txn_count, 8'd0);

        // Single 300 s grant from source 0
        rst = 1'b0;
        step(); step();
        req = 4'b0001; amt = 8'b0000_0011;
        step();
        check("t1_pulse_add4", pulses, 6'b001000);
        check("t1_ack", ack, 4'b0001);
        check("t1_busy_issue", busy, 1'b1);
        check("t1_tally", tally, 16'd300);
        check("t1_txn", txn_count, 8'd1);
        check("t1_grant_id", grant_id, 2'd0);
        req = 4'b0000;
        step();
        check("t1_hold1_pulse", pulses, 6'b0);
        check("t1_hold1_busy", busy, 1'b1);
        step();
        check("t1_hold2_busy", busy, 1'b1);
        step();
        check("t1_idle_busy", busy, 1'b0);

        // All sources held: round-robin every GAP+2 cycles
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; amt = 8'h00;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_pulse_add1", pulses, 6'b000001);
            check("rr_ack", ack, 32'(1 << (k % 4)));
            check("rr_tally", tally, 32'(60 * (k + 1)));
            for (int j = 0; j < 3; j++) begin
                step();
                check("rr_gap_quiet", pulses, 6'b0);
            end
        end
        req = 4'b0000;
        check("rr_txn", txn_count, 8'd5);

        // Admin priority: adm150, then adm16, then payment source 2
        adm150_req = 1'b1; adm16_req = 1'b1; req = 4'b0100; amt = 8'b0010_0000;
        step();
        check("adm_rst2", pulses, 6'b100000);
        check("adm_ack150", adm_ack, 1'b1);
        check("adm_noack150", ack, 4'b0);
        check("adm_tally150", tally, 16'd300);
        adm150_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("adm_gap1_quiet", pulses, 6'b0);
        end
        step();
        check("adm_rst1", pulses, 6'b010000);
        check("adm_ack16", adm_ack, 1'b1);
        adm16_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("adm_gap2_quiet", pulses, 6'b0);
        end
        step();
        check("adm_pay_add3", pulses, 6'b000100);
        check("adm_pay_ack", ack, 4'b0100);
        check("adm_pay_gid", grant_id, 2'd2);
        check("adm_pay_tally", tally, 16'd480);
        check("adm_pay_txn", txn_count, 8'd6);
        check("adm_pay_noadmack", adm_ack, 1'b0);
        req = 4'b0000;
        step(); step(); step();

        // Admin grant must leave ptr at 3
        adm16_req = 1'b1;
        step();
        check("ptr_adm_rst1", pulses, 6'b010000);
        adm16_req = 1'b0;
        step(); step(); step();
        req = 4'b1001; amt = 8'h00;
        step();
        check("ptr_ack", ack, 4'b1000);
        check("ptr_gid", grant_id, 2'd3);
        check("ptr_tally", tally, 16'd540);
        req = 4'b0000;
        step(); step(); step();

        // Saturation: 218 x 300 = 65400, then one more
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001; amt = 8'b0000_0011;
        repeat (218 * 4) step();
        check("sat_pre_tally", tally, 16'd65400);
        check("sat_pre_txn", txn_count, 8'd218);
        step();
        check("sat_pulse", pulses, 6'b001000);
        check("sat_tally", tally, 16'hFFFF);
        check("sat_txn", txn_count, 8'd219);
        req = 4'b0000;
        step(); step(); step();

        // Reset in the ISSUE cycle aborts everything
        req = 4'b0010; amt = 8'b0000_0100;
        step();
        check("abort_add2", pulses, 6'b000010);
        rst = 1'b1; req = 4'b0000;
        step();
        check("abort_pulses", pulses, 6'b0);
        check("abort_ack", ack, 4'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_tally", tally, 16'd0);
        check("abort_txn", txn_count, 8'd0);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            check("abort_quiet", {busy, pulses}, 7'b0);
        end

        // amt change after the decision is ignored
        req = 4'b0001; amt = 8'h00;
        step();
        check("samp_add1", pulses, 6'b000001);
        check("samp_tally", tally, 16'd60);
        amt = 8'h03; req = 4'b0000;
        step();
        check("samp_hold_quiet", pulses, 6'b0);
        step(); step();
        check("samp_final_busy", busy, 1'b0);
        check("samp_final_tally", tally, 16'd60);
        check("samp_final_txn", txn_count, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
